btn_cmd_arbiter: RTL

BTN_CMD_ARBITER -- requirements
Module: btn_cmd_arbiter

---
 rtl/btn_cmd_arbiter_pkg.sv | 19 +
 rtl/btn_edge_flag.sv | 29 ++
 rtl/btn_cmd_arbiter.sv | 81 ++++++++
 3 files changed

// File: rtl/btn_cmd_arbiter_pkg.sv
// btn_cmd_arbiter_pkg: command codes and arbiter FSM states shared with the game FSM.
package btn_cmd_arbiter_pkg;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_LEFT  = 2'b01;
    localparam logic [1:0] CMD_RIGHT = 2'b10;
    localparam logic [1:0] CMD_DROP  = 2'b11;

    localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
    localparam logic [1:0] ST_ISSUE_ENC   = 2'd1;
    localparam logic [1:0] ST_LOCKOUT_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_ISSUE   = ST_ISSUE_ENC,
        ST_LOCKOUT = ST_LOCKOUT_ENC
    } state_e;

endpackage

// File: rtl/btn_edge_flag.sv
// btn_edge_flag: falling-edge detect on an active-low button with a sticky pending flag.
module btn_edge_flag (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic btn_n_i,
    input  logic clr_i,
    output logic pend_o
);

    logic prev_q;
    logic pend_q;
    logic fall;

    assign fall   = prev_q & ~btn_n_i;
    assign pend_o = pend_q;

    // A new edge beats a same-cycle grant clear so the press is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b1;
            pend_q <= 1'b0;
        end else begin
            prev_q <= btn_n_i;
            pend_q <= en_i ? ((pend_q & ~clr_i) | fall) : 1'b0;
        end
    end

endmodule

// File: rtl/btn_cmd_arbiter.sv
// btn_cmd_arbiter: turns button presses into prioritised, handshaked game commands
// with a fixed lockout between consecutive commands.
module btn_cmd_arbiter
    import btn_cmd_arbiter_pkg::*;
#(
    parameter int LOCKOUT_CLKS = 25000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       btn_left_n,
    input  logic       btn_right_n,
    input  logic       btn_drop_n,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_code,
    output logic       busy
);

    localparam int LK = (LOCKOUT_CLKS < 1) ? 1 : LOCKOUT_CLKS;
    localparam int CW = $clog2(LK + 1);
    localparam logic [CW-1:0] LAST = CW'(LK - 1);

    state_e        state_q, state_d;
    logic [1:0]    code_q, code_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    pend;
    logic [2:0]    clr;

    btn_edge_flag u_left  (.clk(clk), .rst(rst), .en_i(en), .btn_n_i(btn_left_n),  .clr_i(clr[0]), .pend_o(pend[0]));
    btn_edge_flag u_right (.clk(clk), .rst(rst), .en_i(en), .btn_n_i(btn_right_n), .clr_i(clr[1]), .pend_o(pend[1]));
    btn_edge_flag u_drop  (.clk(clk), .rst(rst), .en_i(en), .btn_n_i(btn_drop_n),  .clr_i(clr[2]), .pend_o(pend[2]));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            code_q  <= CMD_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    // Grant priority: DROP > LEFT > RIGHT; grants are suppressed while input is disabled.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        clr     = 3'b000;
        case (state_q)
            ST_IDLE: begin
                if (en && |pend) begin
                    state_d = ST_ISSUE;
                    code_d  = pend[2] ? CMD_DROP : pend[0] ? CMD_LEFT : CMD_RIGHT;
                    clr     = pend[2] ? 3'b100 : pend[0] ? 3'b001 : 3'b010;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    state_d = ST_LOCKOUT;
                    cnt_d   = '0;
                end
            end
            ST_LOCKOUT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cmd_valid = (state_q == ST_ISSUE);
    assign cmd_code  = cmd_valid ? code_q : CMD_NONE;
    assign busy      = (state_q != ST_IDLE);

endmodule
